// File: rtl/pulse_gen.sv
// One-cycle trigger to programmable-length level, with an enforced low gap
// after each pulse and an optional single queued retrigger.
module pulse_gen #(
    parameter int LEN_W  = 8,
    parameter int GAP    = 2,
    parameter bit RETRIG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [LEN_W-1:0] len,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic             drop
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_GAP
    } state_t;

    state_t             state_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               pend_q;
    logic [LEN_W-1:0]   plen_q;
    logic               pulse_q;
    logic               busy_q;
    logic               done_q;
    logic               drop_q;

    logic               trig_take_d;
    logic               trig_rej_d;
    logic               relaunch_d;
    logic [LEN_W-1:0]   relaunch_len_d;
    logic [LEN_W-1:0]   relaunch_cnt_d;
    logic [LEN_W-1:0]   trig_cnt_d;

    // A trigger landing on the exit edge of HIGH/GAP counts as busy, so it is
    // folded into the relaunch decision as if it had already been queued.
    always_comb begin
        trig_take_d    = trig & RETRIG & ~pend_q;
        trig_rej_d     = trig & (~RETRIG | pend_q);
        relaunch_d     = pend_q | trig_take_d;
        relaunch_len_d = pend_q ? plen_q : len;
        relaunch_cnt_d = (relaunch_len_d == '0) ? LEN_W'(1) : relaunch_len_d;
        trig_cnt_d     = (len == '0) ? LEN_W'(1) : len;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            gap_cnt_q <= '0;
            pend_q    <= 1'b0;
            plen_q    <= '0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            drop_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (trig) begin
                        state_q <= ST_HIGH;
                        cnt_q   <= trig_cnt_d;
                        pulse_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    drop_q <= trig_rej_d;
                    if (trig_take_d) begin
                        pend_q <= 1'b1;
                        plen_q <= len;
                    end
                    if (cnt_q == LEN_W'(1)) begin
                        done_q <= 1'b1;
                        if (GAP > 0) begin
                            state_q   <= ST_GAP;
                            gap_cnt_q <= GAP_W'(GAP);
                            pulse_q   <= 1'b0;
                        end else if (relaunch_d) begin
                            cnt_q  <= relaunch_cnt_d;
                            pend_q <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            pulse_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - LEN_W'(1);
                    end
                end
                ST_GAP: begin
                    drop_q <= trig_rej_d;
                    if (trig_take_d) begin
                        pend_q <= 1'b1;
                        plen_q <= len;
                    end
                    if (gap_cnt_q == GAP_W'(1)) begin
                        if (relaunch_d) begin
                            state_q <= ST_HIGH;
                            cnt_q   <= relaunch_cnt_d;
                            pulse_q <= 1'b1;
                            pend_q  <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    pulse_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pulse = pulse_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign drop  = drop_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen: three instances cover GAP=2/RETRIG=1,
// GAP=2/RETRIG=0 and GAP=0/RETRIG=1 against hand-derived waveforms.
module tb_pulse_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig_m, trig_n, trig_z;
    logic [7:0] len_m, len_n, len_z;
    logic       pulse_m, busy_m, done_m, drop_m;
    logic       pulse_n, busy_n, done_n, drop_n;
    logic       pulse_z, busy_z, done_z, drop_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulse_gen #(.LEN_W(8), .GAP(2), .RETRIG(1'b1)) u_main (
        .clk(clk), .rst(rst), .trig(trig_m), .len(len_m),
        .pulse(pulse_m), .busy(busy_m), .done(done_m), .drop(drop_m));

    pulse_gen #(.LEN_W(8), .GAP(2), .RETRIG(1'b0)) u_nore (
        .clk(clk), .rst(rst), .trig(trig_n), .len(len_n),
        .pulse(pulse_n), .busy(busy_n), .done(done_n), .drop(drop_n));

    pulse_gen #(.LEN_W(8), .GAP(0), .RETRIG(1'b1)) u_gap0 (
        .clk(clk), .rst(rst), .trig(trig_z), .len(len_z),
        .pulse(pulse_z), .busy(busy_z), .done(done_z), .drop(drop_z));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic t, input logic [7:0] l);
        case (sel)
            0: begin trig_m = t; len_m = l; end
            1: begin trig_n = t; len_n = l; end
            default: begin trig_z = t; len_z = l; end
        endcase
    endtask

    // Bit i of each expected vector is the output seen after edge i, where
    // edge 0 is the first edge of the sequence.
    task automatic run_seq(input int sel, input string tag, input int n,
                           input logic [31:0] trig_vec,
                           input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                           input logic [31:0] exp_p, input logic [31:0] exp_b,
                           input logic [31:0] exp_d, input logic [31:0] exp_r);
        logic [7:0] lv [3];
        int         k;
        logic [3:0] o;
        lv[0] = l0; lv[1] = l1; lv[2] = l2;
        k = 0;
        for (int i = 0; i < n; i++) begin
            if (trig_vec[i]) begin
                drive(sel, 1'b1, lv[k]);
                k++;
            end else begin
                drive(sel, 1'b0, 8'd0);
            end
            @(posedge clk);
            @(negedge clk);
            drive(sel, 1'b0, 8'd0);
            case (sel)
                0: o = {pulse_m, busy_m, done_m, drop_m};
                1: o = {pulse_n, busy_n, done_n, drop_n};
                default: o = {pulse_z, busy_z, done_z, drop_z};
            endcase
            check_eq($sformatf("%s.pulse@%0d", tag, i), 32'(o[3]), 32'(exp_p[i]));
            check_eq($sformatf("%s.busy@%0d", tag, i), 32'(o[2]), 32'(exp_b[i]));
            check_eq($sformatf("%s.done@%0d", tag, i), 32'(o[1]), 32'(exp_d[i]));
            check_eq($sformatf("%s.drop@%0d", tag, i), 32'(o[0]), 32'(exp_r[i]));
            $display("%s cycle %0d pulse=%b busy=%b done=%b drop=%b", tag, i, o[3], o[2], o[1], o[0]);
        end
    endtask

    initial begin
        int pcnt;
        int dcnt;
        rst = 1'b1;
        trig_m = 1'b0; trig_n = 1'b0; trig_z = 1'b0;
        len_m = '0; len_n = '0; len_z = '0;
        repeat (2) @(negedge clk);
        check_eq("rst.main", 32'({pulse_m, busy_m, done_m, drop_m}), 32'h0);
        check_eq("rst.nore", 32'({pulse_n, busy_n, done_n, drop_n}), 32'h0);
        check_eq("rst.gap0", 32'({pulse_z, busy_z, done_z, drop_z}), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_seq(0, "len5", 9, 32'h1, 8'd5, 8'd0, 8'd0, 32'h1F, 32'h7F, 32'h20, 32'h0);
        run_seq(0, "len0", 5, 32'h1, 8'd0, 8'd0, 8'd0, 32'h1, 32'h7, 32'h2, 32'h0);
        run_seq(0, "retrig", 13, 32'hD, 8'd3, 8'd4, 8'd7, 32'h1E7, 32'h7FF, 32'h208, 32'h8);
        run_seq(1, "nore", 8, 32'h3, 8'd3, 8'd6, 8'd0, 32'h7, 32'h1F, 32'h8, 32'h2);
        run_seq(2, "gap0", 7, 32'h3, 8'd2, 8'd3, 8'd0, 32'h1F, 32'h1F, 32'h24, 32'h0);
        run_seq(0, "gapexit", 9, 32'h9, 8'd1, 8'd2, 8'd0, 32'h19, 32'h7F, 32'h22, 32'h0);
        run_seq(0, "idle1st", 9, 32'h11, 8'd1, 8'd1, 8'd0, 32'h11, 32'h77, 32'h22, 32'h0);

        // Maximum length: exactly 255 high cycles and one done strobe.
        trig_m = 1'b1; len_m = 8'd255;
        @(posedge clk);
        @(negedge clk);
        trig_m = 1'b0; len_m = '0;
        pcnt = 0; dcnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (pulse_m) pcnt++;
            if (done_m) dcnt++;
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("len255.pulses", 32'(pcnt), 32'd255);
        check_eq("len255.done", 32'(dcnt), 32'd1);
        check_eq("len255.busy_end", 32'(busy_m), 32'd0);
        $display("len255 pulses=%0d done=%0d", pcnt, dcnt);

        // Reset in the 3rd cycle of a len=10 pulse with a request queued.
        run_seq(0, "prerst", 3, 32'h3, 8'd10, 8'd4, 8'd0, 32'h7, 32'h7, 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        check_eq("midrst.outs", 32'({pulse_m, busy_m, done_m, drop_m}), 32'h0);
        $display("midrst pulse=%b busy=%b done=%b drop=%b", pulse_m, busy_m, done_m, drop_m);
        @(negedge clk);
        rst = 1'b0;
        run_seq(0, "postrst", 6, 32'h0, 8'd0, 8'd0, 8'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        run_seq(0, "fresh", 6, 32'h1, 8'd2, 8'd0, 8'd0, 32'h3, 32'hF, 32'h4, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
